fifo_port_arbiter: RTL
======================

# fifo_port_arbiter

Sequencer and arbiter that shares the 8-entry, 4-bit decimal-digit FIFO controller between two writers and one reader. It converts level-held request/acknowledge handshakes into the edge-sensitive `eni`/`eno` strobes the FIFO controller expects, guaranteeing at least one low cycle between strobes. It arbitrates fairly among eligible requesters, masking writers while the FIFO is full and the reader while it is empty, and rejects out-of-range digits before they reach the FIFO. It sits between the input front-ends (switch/button debouncers) and the FIFO controller in the lab top level.

## Interface
- `DW`, default 4, data width in bits.
- `MAXVAL`, default 9, largest accepted write value; larger values are rejected.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req0`, `req1` in 1: write requests, level; held until `ackN` or `nackN`.
- `data0`, `data1` in DW: write data, stable while the matching `reqN` is high.
- `ack0`, `ack1` out 1: one-cycle pulse; the write was committed to the FIFO.
- `nack0`, `nack1` out 1: one-cycle pulse; the write was rejected because data > MAXVAL.
- `rreq` in 1: read request, level; held until `rack`.
- `rack` out 1: one-cycle pulse; `rdata` is valid in this cycle.
- `rdata` out DW: read data, combinational pass-through of `fifo_out`.
- `eni` out 1: FIFO write strobe.
- `fifo_in` out DW: FIFO write data, registered.
- `eno` out 1: FIFO read strobe.
- `fifo_out` in DW: FIFO registered output.
- `fifo_full`, `fifo_emp` in 1: FIFO status flags.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WR, WGAP, RD, RGAP, REJ. State is registered, and every strobe or ack is a Moore decode of state.
- IDLE: sample requests and choose a winner through a 3-way round-robin over {W0, W1, R}.
  - W0 is eligible when `req0 & ~fifo_full`; W1 likewise.
  - R is eligible when `rreq & ~fifo_emp`.
  - Search starts after the last-served slot. Reset sets the last-served slot to R, so W0 has first priority.
- Winner is a writer with data ≤ MAXVAL: latch the data into `fifo_in`, record the grant, and go to WR.
- Winner is a writer with data > MAXVAL: go to REJ. `eni` stays 0 and the pointer advances.
- Winner is R: go to RD.
- No eligible requester: stay in IDLE.
- WR: `eni`=1 → WGAP: `eni`=0, `ackN`=1 for the granted writer → IDLE.
- RD: `eno`=1 → RGAP: `eno`=0, `rack`=1 → IDLE.
- REJ: `nackN`=1 for the granted writer → IDLE.
- The gap states guarantee `eni`/`eno` fall between strobes. They also ensure `fifo_full`/`fifo_emp` are already updated when IDLE samples them again.
- A request still high in the cycle after its ack is treated as a new request. Requesters drop `req` on seeing ack.
- Requests blocked by full or empty wait indefinitely in IDLE without an ack. They are not dropped.
- `eni` and `eno` are never high in the same cycle.
- Comparison against MAXVAL is unsigned, at DW bits.

## Timing
- Reset values: state IDLE, `eni`=`eno`=0, `fifo_in`=0, all acks and nacks 0, `busy`=0, pointer=R.
- Reset mid-transaction aborts it: no ack is issued, and the strobe drops asynchronously. The FIFO shares `rst` and resets consistently.
- Write: request seen in IDLE at cycle t.
  - `eni`=1 in t+1; the FIFO commits at the end of t+1.
  - `ack` in t+2; the FSM is back in IDLE at t+3.
- Read: request seen at cycle t.
  - `eno`=1 in t+1; `fifo_out` updates at the end of t+1.
  - `rack` with valid `rdata` in t+2.
- Reject: `nack` in t+1; IDLE at t+2.
- Maximum throughput is one transaction per 3 cycles (2 for a reject).
- Fairness: with all three requesters continuously eligible, the service order is W0, W1, R, W0, …

## Structure
- `fifo_arb_pkg`: state encoding (localparam enum), grant IDs (GNT_W0, GNT_W1, GNT_R), and the default MAXVAL.
- Sub-module `rr_arb3`: combinational 3-way round-robin picker. Inputs are the eligibility vector and last-served ID; outputs are the winner ID and a valid flag. The pointer register lives in the parent.
- Top-level wiring connects `fifo_port_arbiter` to the FIFO controller through `eni`/`eno`/`fifo_in`/`fifo_out`/`fifo_full`/`fifo_emp`.

## Test plan
- Write after reset: reset, FIFO empty, `req0`=1, `data0`=5 → `eni` high for exactly one cycle with `fifo_in`=5, `ack0` two cycles after the request, `fifo_emp` falls.
- Reject: `req1`=1, `data1`=12 → `nack1` one cycle later, `eni` never high, FIFO contents unchanged.
- Full and empty masking:
  - Fill the FIFO with 8 writes (digits 0–7), then hold `req0` with 3 → no `eni`, no ack.
  - Then `rreq` → `rack` with `rdata`=0, after which the pending `req0` completes.
- Fairness: hold `req0`, `req1`, `rreq` on a half-full FIFO → grants in order W0, W1, R, W0, W1, R, each strobe separated by at least one low cycle.
- Reset mid-operation: assert `rst` during WR → `eni` drops immediately, no `ack0`, `busy`=0, and the next grant goes to W0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO port arbiter: FSM states, grant IDs, default limit.
package fifo_arb_pkg;

  // Sequencer states; strobes and acks are decoded directly from these.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WGAP = 3'd2,
    S_RD   = 3'd3,
    S_RGAP = 3'd4,
    S_REJ  = 3'd5
  } state_t;

  // Requester slots in round-robin order.
  typedef enum logic [1:0] {
    GNT_W0 = 2'd0,
    GNT_W1 = 2'd1,
    GNT_R  = 2'd2
  } gnt_t;

  localparam int unsigned DW_DEFAULT     = 4;
  localparam int unsigned MAXVAL_DEFAULT = 9;

  // Slot that follows g in the W0 -> W1 -> R -> W0 rotation.
  function automatic gnt_t next_gnt(input gnt_t g);
    gnt_t n;
    case (g)
      GNT_W0:  n = GNT_W1;
      GNT_W1:  n = GNT_R;
      default: n = GNT_W0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker; the last-served pointer is held by the parent.
module rr_arb3
  import fifo_arb_pkg::*;
(
  input  logic [2:0] i_elig,   // bit0 = W0, bit1 = W1, bit2 = R
  input  gnt_t       i_last,
  output gnt_t       o_win,
  output logic       o_valid
);

  gnt_t w_cand;
  logic w_hit;

  // Walk the three slots starting after i_last; first eligible slot wins.
  always_comb begin
    o_win   = GNT_W0;
    o_valid = 1'b0;
    w_cand  = i_last;
    w_hit   = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_cand = next_gnt(w_cand);
      case (w_cand)
        GNT_W0:  w_hit = i_elig[0];
        GNT_W1:  w_hit = i_elig[1];
        GNT_R:   w_hit = i_elig[2];
        default: w_hit = 1'b0;
      endcase
      if (w_hit && !o_valid) begin
        o_valid = 1'b1;
        o_win   = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Two-writer / one-reader sequencer for the digit FIFO: converts level handshakes
// into gapped eni/eno strobes, arbitrates round-robin, and rejects out-of-range digits.
module fifo_port_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DW     = DW_DEFAULT,
  parameter int unsigned MAXVAL = MAXVAL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          ack0,
  output logic          nack0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          ack1,
  output logic          nack1,
  input  logic          rreq,
  output logic          rack,
  output logic [DW-1:0] rdata,
  output logic          eni,
  output logic [DW-1:0] fifo_in,
  output logic          eno,
  input  logic [DW-1:0] fifo_out,
  input  logic          fifo_full,
  input  logic          fifo_emp,
  output logic          busy
);

  state_t        r_state;
  state_t        w_next;
  gnt_t          r_gnt;
  gnt_t          r_last;
  logic [DW-1:0] r_fifo_in;

  logic [2:0]    w_elig;
  gnt_t          w_win;
  logic          w_win_valid;
  logic [DW-1:0] w_sel_data;
  logic          w_reject;

  // Eligibility: writers masked while full, reader masked while empty.
  always_comb begin
    w_elig = {rreq & ~fifo_emp, req1 & ~fifo_full, req0 & ~fifo_full};
  end

  rr_arb3 u_rr (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_valid (w_win_valid)
  );

  // Data of the winning writer and its range check (unsigned, DW bits).
  always_comb begin
    w_sel_data = (w_win == GNT_W1) ? data1 : data0;
    w_reject   = 32'(w_sel_data) > MAXVAL;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: one decision per visit to IDLE, fixed sequences otherwise.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          if (w_win == GNT_R) w_next = S_RD;
          else if (w_reject)  w_next = S_REJ;
          else                w_next = S_WR;
        end
      end
      S_WR:    w_next = S_WGAP;
      S_WGAP:  w_next = S_IDLE;
      S_RD:    w_next = S_RGAP;
      S_RGAP:  w_next = S_IDLE;
      S_REJ:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant bookkeeping: pointer advances on every grant, rejects included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt     <= GNT_W0;
      r_last    <= GNT_R;
      r_fifo_in <= '0;
    end else if (r_state == S_IDLE && w_win_valid) begin
      r_gnt  <= w_win;
      r_last <= w_win;
      if (w_win != GNT_R && !w_reject) r_fifo_in <= w_sel_data;
    end
  end

  // Moore output decode; async reset of r_state drops strobes immediately.
  always_comb begin
    eni   = 1'b0;
    eno   = 1'b0;
    ack0  = 1'b0;
    ack1  = 1'b0;
    nack0 = 1'b0;
    nack1 = 1'b0;
    rack  = 1'b0;
    case (r_state)
      S_WR:   eni  = 1'b1;
      S_WGAP: begin
        ack0 = (r_gnt == GNT_W0);
        ack1 = (r_gnt == GNT_W1);
      end
      S_RD:   eno  = 1'b1;
      S_RGAP: rack = 1'b1;
      S_REJ:  begin
        nack0 = (r_gnt == GNT_W0);
        nack1 = (r_gnt == GNT_W1);
      end
      default: ;
    endcase
    busy    = (r_state != S_IDLE);
    fifo_in = r_fifo_in;
    rdata   = fifo_out;
  end

endmodule
